// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Memory-side responder for the L2 physical-memory port. It takes one
//   s_line-bit read or write from the L2 and runs it as a burst of
//   s_line/s_burst beats of s_burst bits to main memory. Read beats are
//   assembled into line_rdata. Completion is a single-cycle line_resp.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   line_read/line_write  L2 request strobes, held until line_resp
//   line_address          line address from L2
//   line_wdata            writeback line
//   line_rdata            assembled fill line
//   line_resp             one-cycle completion pulse
//   burst_read/write      memory strobes, high for the whole burst
//   burst_address         latched line address, offset bits cleared
//   burst_wdata           current write beat
//   burst_rdata           current read beat from memory
//   burst_resp            memory accepts/returns one beat this cycle
module cacheline_adapter #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [31:0]         line_address,
  input  logic [s_line-1:0]   line_wdata,
  output logic [s_line-1:0]   line_rdata,
  output logic                line_resp,
  output logic                burst_read,
  output logic                burst_write,
  output logic [31:0]         burst_address,
  output logic [s_burst-1:0]  burst_wdata,
  input  logic [s_burst-1:0]  burst_rdata,
  input  logic                burst_resp
);

  localparam int BEATS = s_line / s_burst;
  localparam int CW    = $clog2(BEATS);
  localparam logic [31:0] OFS_MASK = (32'd1 << s_offset) - 32'd1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q;
  logic [BEATS-1:0][s_burst-1:0] wline, rline;

  wire beat = burst_resp && (state == READ || state == WRITE);

  // Next-state logic; a writeback wins over a fill when both are asked for.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (line_write)     state_n = WRITE;
               else if (line_read) state_n = READ;
      READ:    if (burst_resp && cnt == LAST) state_n = DONE;
      WRITE:   if (burst_resp && cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Beat counter wraps naturally on the last beat; DONE forces it home.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (beat)          cnt <= cnt + 1'b1;
    else if (state == DONE) cnt <= '0;
  end

  // Request latches: sampled only in IDLE so later L2 changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wline  <= '0;
    end else if (state == IDLE && (line_write || line_read)) begin
      addr_q <= line_address & ~OFS_MASK;
      if (line_write) wline <= line_wdata;
    end
  end

  // Read assembly: only the addressed beat slot is written, the rest of
  // the previous line is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rline <= '0;
    else if (state == READ && burst_resp) begin
      for (int b = 0; b < BEATS; b++)
        if (cnt == CW'(b)) rline[b] <= burst_rdata;
    end
  end

  assign line_rdata    = rline;
  assign line_resp     = (state == DONE);
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign burst_address = addr_q;
  assign burst_wdata   = (state == WRITE) ? wline[cnt] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter
//   Directed bench for cacheline_adapter: a per-cycle vector table
//   (inputs for the cycle, outputs expected in that cycle), followed by a
//   hand-written mid-burst reset sequence and a fresh read.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_read = 1'b0, line_write = 1'b0;
  logic [31:0]  line_address = '0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp, burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, bresp;
    logic [63:0]  brdata;
    logic [31:0]  laddr;
    logic [255:0] lwdata;
    logic e_br, e_bw, e_lr;
    logic [63:0]  e_bwd;
    logic [31:0]  e_addr;
    logic [255:0] e_rdata;
  } vec_t;

  localparam logic [63:0] R1 = 64'h1111_1111_1111_1111, R2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] R3 = 64'h3333_3333_3333_3333, R4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] R5 = 64'h5555_5555_5555_5555, R6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] R7 = 64'h7777_7777_7777_7777, R8 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF, D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hA5A5_A5A5_5A5A_5A5A, D3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] W0 = 64'h1000_0000_0000_0001, W1 = 64'h2000_0000_0000_0002;
  localparam logic [63:0] W2 = 64'h3000_0000_0000_0003, W3 = 64'h4000_0000_0000_0004;
  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [255:0] LA = {R4, R3, R2, R1};
  localparam logic [255:0] LB = {R8, R7, R6, R5};
  localparam logic [255:0] WL = {D3, D2, D1, D0};
  localparam logic [255:0] WB = {W3, W2, W1, W0};
  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [31:0] A1 = 32'h0000_1220, AW = 32'h0000_ABC0;
  localparam logic [31:0] A2 = 32'h0000_2000, A3 = 32'h0000_3040;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic rd, wr, bresp, input logic [63:0] brd,
                              input logic [31:0] la, input logic [255:0] lw,
                              input logic ebr, ebw, elr, input logic [63:0] ebwd,
                              input logic [31:0] ea, input logic [255:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bresp = bresp; v.brdata = brd; v.laddr = la; v.lwdata = lw;
    v.e_br = ebr; v.e_bw = ebw; v.e_lr = elr; v.e_bwd = ebwd; v.e_addr = ea; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string p, input logic br, bw, lr, input logic [63:0] bwd,
                         input logic [31:0] ad, input logic [255:0] rd);
    chk({p, " burst_read"},    256'(burst_read),    256'(br));
    chk({p, " burst_write"},   256'(burst_write),   256'(bw));
    chk({p, " line_resp"},     256'(line_resp),     256'(lr));
    chk({p, " burst_wdata"},   256'(burst_wdata),   256'(bwd));
    chk({p, " burst_address"}, 256'(burst_address), 256'(ad));
    chk({p, " line_rdata"},    line_rdata,          rd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // read, back-to-back beats
    tbl.push_back(mk(1,0,0,0,  32'h1234,0,    0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,R1, 32'h1234,0,    1,0,0,0,A1,0));
    tbl.push_back(mk(1,0,1,R2, 32'h1234,0,    1,0,0,0,A1,{192'd0,R1}));
    tbl.push_back(mk(1,0,1,R3, 32'h1234,0,    1,0,0,0,A1,{128'd0,R2,R1}));
    tbl.push_back(mk(1,0,1,R4, 32'h1234,0,    1,0,0,0,A1,{64'd0,R3,R2,R1}));
    tbl.push_back(mk(1,0,0,0,  32'h1234,0,    0,0,1,0,A1,LA));
    tbl.push_back(mk(0,0,0,0,  32'h1234,0,    0,0,0,0,A1,LA));
    // spurious burst_resp and address wiggle in IDLE
    tbl.push_back(mk(0,0,1,BAD,32'h9999_9999,0, 0,0,0,0,A1,LA));
    tbl.push_back(mk(0,0,1,BAD,32'h9999_9999,0, 0,0,0,0,A1,LA));
    // write with gaps; line inputs scrambled after sampling
    tbl.push_back(mk(0,1,0,0,32'hABCD,WL,        0,0,0,0, A1,LA));
    tbl.push_back(mk(0,1,1,0,32'hFFFF_FFFF,ONES, 0,1,0,D0,AW,LA));
    tbl.push_back(mk(0,1,0,0,32'hFFFF_FFFF,ONES, 0,1,0,D1,AW,LA));
    tbl.push_back(mk(0,1,1,0,32'hFFFF_FFFF,ONES, 0,1,0,D1,AW,LA));
    tbl.push_back(mk(0,1,0,0,32'hFFFF_FFFF,ONES, 0,1,0,D2,AW,LA));
    tbl.push_back(mk(0,1,1,0,32'hFFFF_FFFF,ONES, 0,1,0,D2,AW,LA));
    tbl.push_back(mk(0,1,0,0,32'hFFFF_FFFF,ONES, 0,1,0,D3,AW,LA));
    tbl.push_back(mk(0,1,1,0,32'hFFFF_FFFF,ONES, 0,1,0,D3,AW,LA));
    tbl.push_back(mk(0,1,0,0,32'hFFFF_FFFF,ONES, 0,0,1,0, AW,LA));
    tbl.push_back(mk(0,0,0,0,32'hFFFF_FFFF,ONES, 0,0,0,0, AW,LA));
    // read+write together: writeback first, then fill to another set
    tbl.push_back(mk(1,1,0,0,32'h2000,WB, 0,0,0,0, AW,LA));
    tbl.push_back(mk(1,1,1,0,32'h2000,WB, 0,1,0,W0,A2,LA));
    tbl.push_back(mk(1,1,1,0,32'h2000,WB, 0,1,0,W1,A2,LA));
    tbl.push_back(mk(1,1,1,0,32'h2000,WB, 0,1,0,W2,A2,LA));
    tbl.push_back(mk(1,1,1,0,32'h2000,WB, 0,1,0,W3,A2,LA));
    tbl.push_back(mk(1,0,0,0,32'h3040,WB, 0,0,1,0, A2,LA));
    tbl.push_back(mk(1,0,0,0,32'h3040,WB, 0,0,0,0, A2,LA));
    tbl.push_back(mk(1,0,1,R5, 32'h7777_7777,0, 1,0,0,0,A3,LA));
    tbl.push_back(mk(1,0,0,BAD,32'h7777_7777,0, 1,0,0,0,A3,{R4,R3,R2,R5}));
    tbl.push_back(mk(1,0,1,R6, 32'h7777_7777,0, 1,0,0,0,A3,{R4,R3,R2,R5}));
    tbl.push_back(mk(1,0,1,R7, 32'h7777_7777,0, 1,0,0,0,A3,{R4,R3,R6,R5}));
    tbl.push_back(mk(1,0,1,R8, 32'h7777_7777,0, 1,0,0,0,A3,{R4,R7,R6,R5}));
    tbl.push_back(mk(1,0,0,0,  32'h7777_7777,0, 0,0,1,0,A3,LB));
    tbl.push_back(mk(0,0,0,0,  32'h7777_7777,0, 0,0,0,0,A3,LB));

    // reset state
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      chk_all($sformatf("row%0d", i), tbl[i].e_br, tbl[i].e_bw, tbl[i].e_lr,
              tbl[i].e_bwd, tbl[i].e_addr, tbl[i].e_rdata);
      line_read    = tbl[i].rd;
      line_write   = tbl[i].wr;
      burst_resp   = tbl[i].bresp;
      burst_rdata  = tbl[i].brdata;
      line_address = tbl[i].laddr;
      line_wdata   = tbl[i].lwdata;
      step();
    end

    // reset after two read beats
    line_read = 1'b1; line_address = 32'h0000_5678; burst_resp = 1'b0;
    step();
    burst_resp = 1'b1; burst_rdata = R1; step();
    burst_rdata = R2; step();
    chk("pre-rst burst_read", 256'(burst_read), 256'(1'b1));
    chk("pre-rst line_rdata", line_rdata, {R8, R7, R2, R1});
    burst_resp = 1'b0; line_read = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("async-rst", 0, 0, 0, 0, 0, 0);
    step();
    chk("in-rst line_resp", 256'(line_resp), 256'(1'b0));
    #2 rst = 1'b0;
    step();
    chk_all("post-rst", 0, 0, 0, 0, 0, 0);

    // fresh read after reset: beats must start again at slot 0
    line_read = 1'b1; line_address = 32'h0000_00FF;
    step();
    chk("fresh addr", 256'(burst_address), 256'(32'h0000_00E0));
    burst_resp = 1'b1; burst_rdata = R5; step();
    chk("fresh beat0", line_rdata, {192'd0, R5});
    burst_rdata = R6; step();
    burst_rdata = R7; step();
    burst_rdata = R8; step();
    burst_resp = 1'b0;
    chk("fresh line_resp", 256'(line_resp), 256'(1'b1));
    chk("fresh line_rdata", line_rdata, LB);
    line_read = 1'b0;
    step();
    chk("fresh idle resp", 256'(line_resp), 256'(1'b0));
    chk("fresh idle read", 256'(burst_read), 256'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
